// File: rtl/ultrasonic_presence.sv
// Ultrasonic ranger: trigger/echo timing, windowed distance average
// and debounced presence detection.
module ultrasonic_presence #(
  parameter int PERIOD_CYC  = 30_000_000,
  parameter int TRIG_CYC    = 1000,
  parameter int TICK_CYC    = 580,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int DIST_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int HOLD_CNT    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              echo,
  input  logic [DIST_W-1:0] near_thresh,
  input  logic [DIST_W-1:0] far_thresh,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout_err,
  output logic              present
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DIST_W + AVG_LOG2;
  localparam int CMAX  = (PERIOD_CYC > TRIG_CYC) ? PERIOD_CYC : TRIG_CYC;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int PW    = $clog2(TICK_CYC + 1);
  localparam int HW    = $clog2(HOLD_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRIGGER,
    WAIT_ECHO,
    MEASURE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DIST_W-1:0] raw_q, raw_d, raw_inc;
  logic              tick, to_evt;
  logic              echo_s1_q, echo_s2_q, echo_s3_q;
  logic              echo_rise, echo_fall;
  logic              smp_vld_q, smp_vld_d;
  logic [DIST_W-1:0] smp_q, smp_d;
  logic              dist_valid_q, timeout_err_q;
  logic [DIST_W-1:0] dist_q;
  logic [DIST_W-1:0] buf_q [DEPTH];
  logic [AVG_LOG2-1:0] idx_q;
  logic [SW-1:0]     sum_q, sum_d;
  logic              fill_q, wrap;
  logic [DIST_W-1:0] avg, new_dist;
  logic              is_far, is_near;
  logic              cls_far, cls_near, cls_mid;
  logic [HW-1:0]     near_q, near_d, far_q, far_d;
  logic              present_q, present_d;

  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    presc_d   = presc_q;
    raw_d     = raw_q;
    smp_vld_d = 1'b0;
    smp_d     = smp_q;
    to_evt    = 1'b0;
    tick      = (presc_q == PW'(TICK_CYC - 1));
    raw_inc   = (tick && raw_q != '1) ? raw_q + 1'b1 : raw_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      to_d    = '0;
      presc_d = '0;
      raw_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q == CW'(PERIOD_CYC - 1)) begin
            state_d = TRIGGER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TRIGGER: begin
          if (cnt_q == CW'(TRIG_CYC - 1)) begin
            state_d = WAIT_ECHO;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_ECHO, MEASURE: begin
          to_d = to_q + 1'b1;
          // timeout wins over a coincident echo edge
          if (to_q == TW'(TIMEOUT_CYC - 1)) begin
            to_evt  = 1'b1;
            state_d = IDLE;
            to_d    = '0;
            presc_d = '0;
            raw_d   = '0;
          end else if (state_q == WAIT_ECHO) begin
            if (echo_rise) begin
              state_d = MEASURE;
              presc_d = '0;
              raw_d   = '0;
            end
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            raw_d   = raw_inc;
            if (echo_fall) begin
              smp_vld_d = 1'b1;
              smp_d     = raw_inc;
              state_d   = IDLE;
              to_d      = '0;
              presc_d   = '0;
              raw_d     = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sum_d    = sum_q - SW'(buf_q[idx_q]) + SW'(smp_q);
    wrap     = (idx_q == AVG_LOG2'(DEPTH - 1));
    avg      = DIST_W'(sum_d >> AVG_LOG2);
    new_dist = (fill_q || wrap) ? avg : smp_q;
    is_far   = new_dist > far_thresh;
    is_near  = new_dist <= near_thresh;
    cls_far  = to_evt | (smp_vld_q & is_far);
    cls_near = smp_vld_q & ~to_evt & ~is_far & is_near;
    cls_mid  = smp_vld_q & ~to_evt & ~is_far & ~is_near;
  end

  always_comb begin
    near_d    = near_q;
    far_d     = far_q;
    present_d = present_q;
    unique case (1'b1)
      cls_far: begin
        near_d = '0;
        if (far_q == HW'(HOLD_CNT - 1)) present_d = 1'b0;
        else far_d = far_q + 1'b1;
      end
      cls_near: begin
        far_d = '0;
        if (near_q == HW'(HOLD_CNT - 1)) present_d = 1'b1;
        else near_d = near_q + 1'b1;
      end
      cls_mid: begin
        near_d = '0;
        far_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      to_q          <= '0;
      presc_q       <= '0;
      raw_q         <= '0;
      echo_s1_q     <= 1'b0;
      echo_s2_q     <= 1'b0;
      echo_s3_q     <= 1'b0;
      smp_vld_q     <= 1'b0;
      smp_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      presc_q       <= presc_d;
      raw_q         <= raw_d;
      echo_s1_q     <= echo;
      echo_s2_q     <= echo_s1_q;
      echo_s3_q     <= echo_s2_q;
      smp_vld_q     <= smp_vld_d;
      smp_q         <= smp_d;
      timeout_err_q <= to_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      fill_q       <= 1'b0;
      dist_q       <= '0;
      dist_valid_q <= 1'b0;
      near_q       <= '0;
      far_q        <= '0;
      present_q    <= 1'b0;
    end else begin
      dist_valid_q <= smp_vld_q;
      if (smp_vld_q) begin
        buf_q[idx_q] <= smp_q;
        idx_q        <= idx_q + 1'b1;
        sum_q        <= sum_d;
        fill_q       <= fill_q | wrap;
        dist_q       <= new_dist;
      end
      near_q    <= near_d;
      far_q     <= far_d;
      present_q <= present_d;
    end
  end

  assign trig        = (state_q == TRIGGER);
  assign distance    = dist_q;
  assign dist_valid  = dist_valid_q;
  assign timeout_err = timeout_err_q;
  assign present     = present_q;

endmodule

// File: doc/ultrasonic_presence.md
ULTRASONIC_PRESENCE -- requirements
Module: ultrasonic_presence

Interface
REQ-001 Parameters SHALL be:
- PERIOD_CYC, 30_000_000, clocks from end of one measurement to next trigger.
- TRIG_CYC, 1000, trigger pulse width in clocks.
- TICK_CYC, 580, clocks per 0.1 cm distance unit.
- TIMEOUT_CYC, 3_000_000, max clocks from trigger end to echo fall.
- DIST_W, 12, distance width.
- AVG_LOG2, 2, log2 of averaging window depth.
- HOLD_CNT, 3, consecutive samples needed to change presence.
REQ-002 Ports SHALL be:
- clk, input, 1, single system clock, all logic rising-edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, measurement run enable.
- echo, input, 1, asynchronous sensor echo.
- near_thresh, input, DIST_W, presence-set threshold.
- far_thresh, input, DIST_W, presence-clear threshold.
- trig, output, 1, sensor trigger pulse.
- distance, output, DIST_W, windowed average distance.
- dist_valid, output, 1, one-cycle strobe on distance update.
- timeout_err, output, 1, one-cycle strobe on echo timeout.
- present, output, 1, debounced presence flag.

Function
REQ-003 echo SHALL pass a 2-flop synchroniser before any use; edges SHALL be detected on the synchronised signal.
REQ-004 FSM states SHALL be IDLE, TRIGGER, WAIT_ECHO, MEASURE.
REQ-005 IDLE: count PERIOD_CYC clocks while enable=1, then enter TRIGGER with counter cleared.
REQ-006 TRIGGER: trig=1 for exactly TRIG_CYC clocks, then trig=0 and enter WAIT_ECHO.
REQ-007 WAIT_ECHO: synchronised echo rising edge enters MEASURE with tick prescaler and raw counter at 0.
REQ-008 MEASURE: raw counter increments once per TICK_CYC clocks while echo high; saturates at 2^DIST_W-1 (no wrap).
REQ-009 MEASURE: echo falling edge latches raw counter as one sample and returns to IDLE.
REQ-010 Timeout counter SHALL start on TRIGGER exit and run through WAIT_ECHO and MEASURE; on reaching TIMEOUT_CYC, pulse timeout_err for one cycle, discard sample, return to IDLE.
REQ-011 Simultaneous echo fall and timeout SHALL be treated as timeout.
REQ-012 Samples SHALL enter a 2^AVG_LOG2-deep circular buffer with running sum of width DIST_W+AVG_LOG2; distance = sum >> AVG_LOG2.
REQ-013 Until the buffer has been filled once after reset, distance SHALL equal the latest raw sample; thereafter, the window average.
REQ-014 distance SHALL update and dist_valid pulse exactly 2 clocks after the echo falling edge is detected; distance holds between updates.
REQ-015 Near sample: averaged distance <= near_thresh; far sample: averaged distance > far_thresh, or a timeout; values in between SHALL reset both streak counters.
REQ-016 present SHALL set after HOLD_CNT consecutive near samples and clear after HOLD_CNT consecutive far samples; opposite-class sample resets the streak.
REQ-017 If near_thresh >= far_thresh, thresholds SHALL be used as given, with far taking priority when both match.
REQ-018 enable=0 SHALL, on the next clock, force IDLE, trig=0, and clear counters; present, distance and the buffer SHALL be retained.
REQ-019 enable rising from 0 SHALL wait a full PERIOD_CYC before triggering.

Reset
REQ-020 reset_n=0 SHALL asynchronously set state IDLE, trig=0, distance=0, dist_valid=0, timeout_err=0, present=0, clear buffer, sum, fill flag, streaks and all counters.
REQ-021 Reset deasserted mid-measurement SHALL restart from IDLE with no sample emitted.

Verification
REQ-022 PERIOD_CYC=100, TRIG_CYC=10, TICK_CYC=4: echo high 400 clocks -> first distance=100, dist_valid one cycle, trig width exactly 10.
REQ-023 Four samples 100,200,300,400 (AVG_LOG2=2) -> distances 100,200,300,250; fifth sample 500 -> 350.
REQ-024 Echo never rises, TIMEOUT_CYC=1000 -> timeout_err pulse 1000 clocks after trig falls, no dist_valid, FSM back to IDLE; 3 timeouts clear present.
REQ-025 near_thresh=150, far_thresh=200, HOLD_CNT=3: averaged 120,120,180,120,120,120 -> present rises only after sixth sample.
REQ-026 Echo held high 2^DIST_W*TICK_CYC+50 clocks with large TIMEOUT_CYC -> raw sample 4095, no wrap.
REQ-027 reset_n pulsed low during MEASURE, and enable dropped during TRIGGER -> trig=0 within one clock, no dist_valid, outputs per REQ-018/REQ-020.
